// File: rtl/data_path_pkg.sv
// Shared encodings and ALU for data_path_pipe.
// Operands are MSB-aligned in an ALU_W-bit word so carry, overflow and sign
// come from fixed bit positions whatever the datapath width (WIDTH <= ALU_W).
package data_path_pkg;

  localparam int ALU_W = 64;

  localparam logic [31:0] OP_AND = 32'd0;
  localparam logic [31:0] OP_OR  = 32'd1;
  localparam logic [31:0] OP_XOR = 32'd2;
  localparam logic [31:0] OP_MOV = 32'd3;
  localparam logic [31:0] OP_ADD = 32'd4;
  localparam logic [31:0] OP_SUB = 32'd5;
  localparam logic [31:0] OP_CMP = 32'd6;
  localparam logic [31:0] OP_LSH = 32'd7;

  // flags_out = {C,L,F,Z,N}
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 3;
  localparam int FLAG_C = 4;

  typedef struct packed {
    logic [ALU_W-1:0] res;
    logic [4:0]       flags;
  } alu_out_t;

  // a/b are MSB-aligned (low pad bits zero); keep masks off the pad bits so
  // right shifts cannot leak into Z. Unknown opcodes return a and fin.
  function automatic alu_out_t alu_op(input logic [31:0] op,
                                      input logic [ALU_W-1:0] a,
                                      input logic [ALU_W-1:0] b,
                                      input logic [ALU_W-1:0] keep,
                                      input logic [3:0] sh,
                                      input logic sh_right,
                                      input logic [4:0] fin);
    logic [ALU_W:0]   sum;
    logic [ALU_W:0]   diff;
    logic [ALU_W-1:0] r;
    logic [4:0]       f;
    logic             ovf_add;
    logic             ovf_sub;
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    ovf_add = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
    ovf_sub = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
    r = a;
    f = fin;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_MOV: r = b;
      OP_LSH: r = sh_right ? (a >> sh) : (a << sh);
      OP_ADD: begin
        r         = sum[ALU_W-1:0];
        f[FLAG_C] = sum[ALU_W];
        f[FLAG_F] = ovf_add;
      end
      OP_SUB, OP_CMP: begin
        r         = diff[ALU_W-1:0];
        f[FLAG_C] = diff[ALU_W];
        f[FLAG_L] = diff[ALU_W];
        f[FLAG_F] = ovf_sub;
        f[FLAG_N] = diff[ALU_W-1] ^ ovf_sub;
      end
      default: ;
    endcase
    r = r & keep;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LSH, OP_ADD: begin
        f[FLAG_N] = r[ALU_W-1];
        f[FLAG_Z] = ~|r;
      end
      OP_SUB, OP_CMP: f[FLAG_Z] = ~|r;
      default: ;
    endcase
    return '{res: r, flags: f};
  endfunction

endpackage

// File: rtl/data_path_pipe_regfile.sv
// regfile_2r1w: NUM_REGS x WIDTH, two operand reads plus a debug read, all
// combinational from the flops; one synchronous write; async active-low clear.
module regfile_2r1w
  import data_path_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16,
  localparam int SELW    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SELW-1:0]  ra_sel,
  input  logic [SELW-1:0]  rb_sel,
  input  logic [SELW-1:0]  dbg_sel,
  input  logic             we,
  input  logic [SELW-1:0]  wsel,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic [WIDTH-1:0] dbg_data
);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;

  // single write port; reads see the old value until the write edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  regs <= '0;
    else if (we) regs[wsel] <= wdata;
  end

  assign ra_data  = regs[ra_sel];
  assign rb_data  = regs[rb_sel];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/data_path_pipe.sv
// data_path_pipe: two-stage datapath (RD operand capture, EX execute/write-back).
// Build option DATA_PATH_FWD_EN: forward the EX result into operand capture
// instead of stalling one cycle on a read-after-write hazard.
module data_path_pipe
  import data_path_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 16,
  parameter int OPW      = 8,
  localparam int SELW    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [SELW-1:0]  rdest_sel,
  input  logic [SELW-1:0]  rsrc_sel,
  input  logic [WIDTH-1:0] imm_in,
  input  logic             imm_select,
  input  logic             wb_en,
  input  logic             flags_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags_out,
  input  logic [SELW-1:0]  dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int STAGES = 2;
  localparam logic [ALU_W-1:0] KEEP =
    ~((ALU_W'(1) << (ALU_W - WIDTH)) - ALU_W'(1));

  logic [STAGES:1]  vld_pipe;   // [1] = EX valid, [2] = retire pulse
  logic             accept;
  logic [OPW-1:0]   ex_op;
  logic [WIDTH-1:0] ex_a, ex_b, ex_res;
  logic [SELW-1:0]  ex_rdest;
  logic             ex_wb, ex_fl, ex_valid;
  logic [WIDTH-1:0] ra_data, rb_data, op_a, op_b;
  logic             hz_a, hz_b;
  logic [ALU_W-1:0] a_al, b_al;
  alu_out_t         alu;

  assign ex_valid  = vld_pipe[1];
  assign out_valid = vld_pipe[STAGES];

  regfile_2r1w #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .ra_sel   (rdest_sel),
    .rb_sel   (rsrc_sel),
    .dbg_sel  (dbg_sel),
    .we       (ex_valid && ex_wb),
    .wsel     (ex_rdest),
    .wdata    (ex_res),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_data)
  );

  // read-after-write against the instruction sitting in EX
  assign hz_a = ex_valid && ex_wb && (rdest_sel == ex_rdest);
  assign hz_b = ex_valid && ex_wb && !imm_select && (rsrc_sel == ex_rdest);

`ifdef DATA_PATH_FWD_EN
  assign in_ready = 1'b1;
  assign op_a     = hz_a ? ex_res : ra_data;
  assign op_b     = imm_select ? imm_in : (hz_b ? ex_res : rb_data);
`else
  // stall clears itself: nothing enters EX during the stall cycle
  assign in_ready = !(hz_a || hz_b);
  assign op_a     = ra_data;
  assign op_b     = imm_select ? imm_in : rb_data;
`endif

  assign accept = in_valid && in_ready;

  // EX-stage ALU on MSB-aligned operands
  always_comb begin
    a_al   = ALU_W'(ex_a) << (ALU_W - WIDTH);
    b_al   = ALU_W'(ex_b) << (ALU_W - WIDTH);
    alu    = alu_op(32'(ex_op), a_al, b_al, KEEP, ex_b[3:0], ex_b[4], flags_out);
    ex_res = WIDTH'(alu.res >> (ALU_W - WIDTH));
  end

  // RD capture into EX registers; valid shifts toward the retire pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      ex_op    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_rdest <= '0;
      ex_wb    <= 1'b0;
      ex_fl    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) begin
        ex_op    <= opcode;
        ex_a     <= op_a;
        ex_b     <= op_b;
        ex_rdest <= rdest_sel;
        ex_wb    <= wb_en && (32'(opcode) != OP_CMP);
        ex_fl    <= flags_en;
      end
    end
  end

  // retire: latch result and, when enabled, flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      flags_out <= '0;
    end else if (ex_valid) begin
      result <= ex_res;
      if (ex_fl) flags_out <= alu.flags;
    end
  end

endmodule

// File: tb/tb_data_path_pipe.sv
// Directed bench for data_path_pipe: vector table of single instructions plus
// hand sequences for back-to-back hazard, streaming and mid-flight reset.
module tb_data_path_pipe;
  import data_path_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  opcode = '0;
  logic [3:0]  rdest_sel = '0, rsrc_sel = '0, dbg_sel = '0;
  logic [15:0] imm_in = '0;
  logic        imm_select = 1'b0, wb_en = 1'b0, flags_en = 1'b0;
  logic        out_valid;
  logic [15:0] result, dbg_data;
  logic [4:0]  flags_out;

  int checks = 0;
  int errors = 0;

  data_path_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rdest_sel(rdest_sel), .rsrc_sel(rsrc_sel),
    .imm_in(imm_in), .imm_select(imm_select), .wb_en(wb_en),
    .flags_en(flags_en), .out_valid(out_valid), .result(result),
    .flags_out(flags_out), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  rd, rs;
    logic [15:0] imm;
    logic        isel, wb, fe;
    logic [15:0] res;
    logic [4:0]  fl, msk;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [15:0] imm, input logic isel, input logic wb, input logic fe);
    opcode = op; rdest_sel = rd; rsrc_sel = rs; imm_in = imm;
    imm_select = isel; wb_en = wb; flags_en = fe; in_valid = 1'b1;
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    drive(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, vecs[i].isel, vecs[i].wb, vecs[i].fe);
    #1 chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
    chk($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].res));
    chk($sformatf("vec%0d flags", i), 32'(flags_out & vecs[i].msk), 32'(vecs[i].fl & vecs[i].msk));
  endtask

  task automatic chk_reg(input string nm, input logic [3:0] r, input logic [15:0] exp);
    dbg_sel = r;
    #1 chk(nm, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    int stall;
    int pulses;
    bit acc;
    // op, rd, rs, imm, isel, wb, fe, result, flags{C,L,F,Z,N}, mask
    vecs[0]  = '{8'(OP_MOV), 4'd1, 4'd0, 16'hFFFF, 1, 1, 1, 16'hFFFF, 5'b00001, 5'b11111};
    vecs[1]  = '{8'(OP_ADD), 4'd1, 4'd0, 16'h0001, 1, 1, 1, 16'h0000, 5'b10010, 5'b11110};
    vecs[2]  = '{8'(OP_MOV), 4'd6, 4'd0, 16'h8000, 1, 1, 1, 16'h8000, 5'b10001, 5'b11111};
    vecs[3]  = '{8'(OP_SUB), 4'd6, 4'd0, 16'h0001, 1, 1, 1, 16'h7FFF, 5'b00100, 5'b11110};
    vecs[4]  = '{8'(OP_MOV), 4'd2, 4'd0, 16'h0003, 1, 1, 1, 16'h0003, 5'b00100, 5'b11111};
    vecs[5]  = '{8'(OP_MOV), 4'd3, 4'd0, 16'h0005, 1, 1, 0, 16'h0005, 5'b00100, 5'b11111};
    vecs[6]  = '{8'(OP_CMP), 4'd2, 4'd3, 16'h0000, 0, 1, 1, 16'hFFFE, 5'b11001, 5'b11111};
    vecs[7]  = '{8'(OP_MOV), 4'd7, 4'd2, 16'h0000, 0, 1, 0, 16'h0003, 5'b11001, 5'b11111};
    vecs[8]  = '{8'(OP_MOV), 4'd5, 4'd0, 16'h0001, 1, 1, 0, 16'h0001, 5'b11001, 5'b11111};
    vecs[9]  = '{8'(OP_LSH), 4'd5, 4'd0, 16'h000F, 1, 1, 1, 16'h8000, 5'b11001, 5'b11111};
    vecs[10] = '{8'(OP_LSH), 4'd5, 4'd0, 16'h0011, 1, 1, 1, 16'h4000, 5'b11000, 5'b11111};
    vecs[11] = '{8'(OP_XOR), 4'd5, 4'd0, 16'h4000, 1, 1, 1, 16'h0000, 5'b11010, 5'b11111};
    vecs[12] = '{8'(OP_OR),  4'd5, 4'd0, 16'h00F0, 1, 1, 1, 16'h00F0, 5'b11000, 5'b11111};
    vecs[13] = '{8'(OP_AND), 4'd5, 4'd0, 16'h0F3C, 1, 1, 1, 16'h0030, 5'b11000, 5'b11111};
    vecs[14] = '{8'hFF,      4'd5, 4'd0, 16'h1234, 1, 1, 1, 16'h0030, 5'b11000, 5'b11111};
    vecs[15] = '{8'(OP_MOV), 4'd8, 4'd0, 16'h7FFF, 1, 1, 0, 16'h7FFF, 5'b11000, 5'b11111};
    vecs[16] = '{8'(OP_ADD), 4'd8, 4'd0, 16'h0001, 1, 1, 1, 16'h8000, 5'b01100, 5'b11110};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst flags", 32'(flags_out), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk_reg("rst r3", 4'd3, 16'h0000);

    for (int i = 0; i < 17; i++) run_vec(i);
    @(negedge clk);
    chk("out_valid single pulse", 32'(out_valid), 32'd0);
    chk_reg("cmp kept r2", 4'd2, 16'h0003);
    chk_reg("undef kept r5", 4'd5, 16'h0030);
    chk_reg("r8", 4'd8, 16'h8000);

    // back-to-back MOV r4<-7 ; ADD r4+1
    @(negedge clk);
    drive(8'(OP_MOV), 4'd4, 4'd0, 16'h0007, 1, 1, 0);
    @(posedge clk);
    #1 drive(8'(OP_ADD), 4'd4, 4'd0, 16'h0001, 1, 1, 0);
    stall = 0;
    acc = 0;
    for (int c = 0; c < 5 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      else stall++;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (!acc) chk("b2b accept timeout", 32'd0, 32'd1);
`ifdef DATA_PATH_FWD_EN
    chk("b2b stall cycles", 32'(stall), 32'd0);
`else
    chk("b2b stall cycles", 32'(stall), 32'd1);
`endif
    @(posedge clk);
    @(negedge clk);
    chk("b2b out_valid", 32'(out_valid), 32'd1);
    chk("b2b result", 32'(result), 32'h0008);
    chk_reg("b2b r4", 4'd4, 16'h0008);

    // stream of independent MOVs r0..r7
    pulses = 0;
    dbg_sel = 4'd0;
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      if (j < 8) drive(8'(OP_MOV), 4'(j), 4'(j), 16'h0010 + 16'(j), 1, 1, 0);
      else in_valid = 1'b0;
      #1;
      if (j < 8) chk($sformatf("stream in_ready %0d", j), 32'(in_ready), 32'd1);
      if (j == 1) chk("dbg old before wb", 32'(dbg_data), 32'h0000);
      if (j == 2) chk("dbg new after wb", 32'(dbg_data), 32'h0010);
      if (out_valid) pulses++;
      @(posedge clk);
    end
    chk("stream pulses", 32'(pulses), 32'd8);
    for (int r = 0; r < 8; r++)
      chk_reg($sformatf("stream r%0d", r), 4'(r), 16'h0010 + 16'(r));

    // reset while ADD r10 sits in EX
    @(negedge clk);
    drive(8'(OP_ADD), 4'd10, 4'd0, 16'h0005, 1, 1, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst flags", 32'(flags_out), 32'd0);
    chk("midrst result", 32'(result), 32'd0);
    chk_reg("midrst r4", 4'd4, 16'h0000);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("postrst out_valid", 32'(out_valid), 32'd0);
    chk("postrst in_ready", 32'(in_ready), 32'd1);
    chk_reg("postrst r10", 4'd10, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
